bcd_seg_scan: RTL and testbench

Display stage directly downstream of the `bcd` counter. It snapshots a packed vector of BCD digits and time-multiplexes them onto one shared seven-segment bus with one-hot digit enables. It offers optional leading-zero blanking, shows a dash for invalid codes, and updates the display only at frame boundaries so digits never tear. It gives the single-digit `count` output a visible consumer, and it scales to cascaded multi-digit counters.

---
 rtl/bcd_seg_scan.sv | 131 +++++++++++++
 tb/tb_bcd_seg_scan.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/bcd_seg_scan.sv
// bcd_seg_scan: multiplexed seven-segment scanner for a packed BCD vector.
// Digits are scanned least significant first. Each digit stays enabled for
// PRESCALE cycles. New values are taken only at frame boundaries, so a frame
// never mixes old and new digits. Optional leading-zero blanking is provided.
module bcd_seg_scan #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   digits_in,
    input  logic                  blank_lz,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_start
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [PW-1:0]       pc;
    logic [IW-1:0]       idx;
    logic [4*DIGITS-1:0] shown;
    logic [4*DIGITS-1:0] pending;
    logic                pend_v;

    logic                pc_wrap;
    logic                idx_last;
    logic                boundary;
    logic [3:0]          cur_digit;
    logic                cur_lz;
    logic [DIGITS-1:0]   lz;
    logic [6:0]          seg_dec;
    logic [DIGITS-1:0]   an_nxt;

    assign pc_wrap  = (pc == PW'(PRESCALE - 1));
    assign idx_last = (idx == IW'(DIGITS - 1));
    assign boundary = pc_wrap && idx_last;

    // Prescaler and scan index; idx wrapping to 0 marks the frame boundary.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc  <= '0;
            idx <= '0;
        end else if (pc_wrap) begin
            pc  <= '0;
            idx <= idx_last ? '0 : idx + IW'(1);
        end else begin
            pc  <= pc + PW'(1);
        end
    end

    // Double-buffered snapshot: loads go to pending, shown changes only at boundaries.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shown   <= '0;
            pending <= '0;
            pend_v  <= 1'b0;
        end else if (boundary) begin
            if (load) begin
                shown  <= digits_in;
                pend_v <= 1'b0;
            end else if (pend_v) begin
                shown  <= pending;
                pend_v <= 1'b0;
            end
        end else if (load) begin
            pending <= digits_in;
            pend_v  <= 1'b1;
        end
    end

    // Leading-zero map: lz[k] is set when digit k and every digit above it are zero.
    always_comb begin
        logic run;
        run = 1'b1;
        lz  = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            int unsigned j;
            j     = DIGITS - 1 - i;
            run   = run && (shown[4*j +: 4] == 4'd0);
            lz[j] = run;
        end
    end

    // Select the digit under the scan index and build the one-hot enable.
    always_comb begin
        cur_digit = 4'd0;
        cur_lz    = 1'b0;
        an_nxt    = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (idx == IW'(i)) begin
                cur_digit = shown[4*i +: 4];
                cur_lz    = (i != 0) && lz[i];
                an_nxt[i] = 1'b1;
            end
        end
    end

    // BCD to segment decode; codes 10..15 show a dash.
    always_comb begin
        case (cur_digit)
            4'd0:    seg_dec = 7'h3F;
            4'd1:    seg_dec = 7'h06;
            4'd2:    seg_dec = 7'h5B;
            4'd3:    seg_dec = 7'h4F;
            4'd4:    seg_dec = 7'h66;
            4'd5:    seg_dec = 7'h6D;
            4'd6:    seg_dec = 7'h7D;
            4'd7:    seg_dec = 7'h07;
            4'd8:    seg_dec = 7'h7F;
            4'd9:    seg_dec = 7'h6F;
            default: seg_dec = 7'h40;
        endcase
    end

    // Registered outputs, one cycle behind the scan state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seg         <= '0;
            an          <= '0;
            frame_start <= 1'b0;
        end else begin
            seg         <= (blank_lz && cur_lz) ? 7'h00 : seg_dec;
            an          <= an_nxt;
            frame_start <= (pc == '0) && (idx == '0);
        end
    end

endmodule

// File: tb/tb_bcd_seg_scan.sv
// Scoreboard bench for bcd_seg_scan (DIGITS=4, PRESCALE=4).
// Stimulus queues the expected segment pattern of each frame; the monitor
// walks every output cycle, pops a frame at its first cycle and compares.
module tb_bcd_seg_scan;

    logic        clk;
    logic        reset;
    logic        load;
    logic [15:0] digits_in;
    logic        blank_lz;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frame_start;

    int          n_cmp;
    int          n_bad;
    int          ecount;
    int          pos;
    bit          mon_en;
    logic [27:0] exp_q[$];
    logic [27:0] cur;

    bcd_seg_scan #(.DIGITS(4), .PRESCALE(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .digits_in   (digits_in),
        .blank_lz    (blank_lz),
        .seg         (seg),
        .an          (an),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edges seen since reset release; edge n leaves ecount == n.
    always @(posedge clk or negedge reset) begin
        if (!reset) ecount <= 0;
        else        ecount <= ecount + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Expected frame, digits listed most significant first.
    task automatic push_frame(input logic [6:0] s3, input logic [6:0] s2,
                              input logic [6:0] s1, input logic [6:0] s0);
        exp_q.push_back({s3, s2, s1, s0});
    endtask

    task automatic wait_edge(input int n);
        while (ecount < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present digits so that they are sampled on edge n.
    task automatic load_at(input int n, input logic [15:0] v);
        wait_edge(n - 1);
        load      = 1'b1;
        digits_in = v;
        wait_edge(n);
        load      = 1'b0;
    endtask

    // Monitor: position within the frame is counted independently of the DUT.
    always @(negedge clk) begin
        if (mon_en) begin
            if (ecount == 0) begin
                pos = 0;
            end else begin
                if (pos == 0) begin
                    if (exp_q.size() == 0) begin
                        chk("frame_queue_nonempty", 32'd0, 32'd1);
                        cur = '0;
                    end else begin
                        cur = exp_q.pop_front();
                    end
                    chk("frame_start_high", {31'd0, frame_start}, 32'd1);
                end else begin
                    chk("frame_start_low", {31'd0, frame_start}, 32'd0);
                end
                chk("an", {28'd0, an}, {28'd0, 4'b0001 << (pos / 4)});
                chk("seg", {25'd0, seg}, {25'd0, cur[7*(pos/4) +: 7]});
                pos = (pos + 1) % 16;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        pos       = 0;
        mon_en    = 1'b0;
        load      = 1'b0;
        digits_in = 16'h0000;
        blank_lz  = 1'b0;
        reset     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_seg", {25'd0, seg}, 32'd0);
        chk("reset_an", {28'd0, an}, 32'd0);
        chk("reset_fs", {31'd0, frame_start}, 32'd0);

        push_frame(7'h3F, 7'h3F, 7'h3F, 7'h3F); // f0 idle zeros
        push_frame(7'h3F, 7'h3F, 7'h3F, 7'h3F); // f1 unchanged by mid-frame load
        push_frame(7'h06, 7'h5B, 7'h4F, 7'h66); // f2 1234
        push_frame(7'h00, 7'h00, 7'h66, 7'h5B); // f3 0042 blanked
        push_frame(7'h00, 7'h00, 7'h00, 7'h3F); // f4 0000 blanked
        push_frame(7'h00, 7'h40, 7'h3F, 7'h3F); // f5 0A00 blanked
        push_frame(7'h3F, 7'h40, 7'h3F, 7'h3F); // f6 0A00 unblanked
        push_frame(7'h6D, 7'h6D, 7'h6D, 7'h6D); // f7 5555 from boundary load
        push_frame(7'h06, 7'h5B, 7'h4F, 7'h66); // f8 1234, cut by reset
        mon_en = 1'b1;

        @(negedge clk);
        reset = 1'b1;

        load_at(22, 16'h1234);
        wait_edge(39);
        blank_lz = 1'b1;
        load_at(40, 16'h0042);
        load_at(56, 16'h0000);
        load_at(72, 16'h0A00);
        wait_edge(96);
        blank_lz = 1'b0;
        load_at(100, 16'h1111);
        load_at(105, 16'h9876);
        load_at(112, 16'h5555);
        load_at(118, 16'h1234);
        load_at(131, 16'h9999);

        wait_edge(138);
        #1;
        reset = 1'b0;
        #1;
        chk("async_reset_seg", {25'd0, seg}, 32'd0);
        chk("async_reset_an", {28'd0, an}, 32'd0);
        chk("async_reset_fs", {31'd0, frame_start}, 32'd0);

        push_frame(7'h3F, 7'h3F, 7'h3F, 7'h3F); // restart from cleared snapshot
        push_frame(7'h3F, 7'h3F, 7'h3F, 7'h3F); // pending 9999 discarded
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        wait_edge(32);
        @(negedge clk);
        #1;
        mon_en = 1'b0;
        chk("frames_consumed", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
